// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared timing record, register map and axis-bound helpers for video_timing_gen
package video_timing_pkg;
  localparam int CW = 16;
  typedef struct packed {
    logic [CW-1:0] hres, h_fp, h_sync, h_bp;
    logic [CW-1:0] vres, v_fp, v_sync, v_bp;
    logic          v_pol, h_pol;
  } timing_t;
  typedef struct packed {
    logic signed [CW-1:0] sta, sync_beg, sync_end, last;
  } axis_t;
  localparam logic [3:0] A_HRES   = 4'd0;
  localparam logic [3:0] A_H_FP   = 4'd1;
  localparam logic [3:0] A_H_SYNC = 4'd2;
  localparam logic [3:0] A_H_BP   = 4'd3;
  localparam logic [3:0] A_VRES   = 4'd4;
  localparam logic [3:0] A_V_FP   = 4'd5;
  localparam logic [3:0] A_V_SYNC = 4'd6;
  localparam logic [3:0] A_V_BP   = 4'd7;
  localparam logic [3:0] A_POL    = 4'd8;
  localparam logic [3:0] A_LCMP   = 4'd10;
  function automatic logic signed [CW-1:0] axis_start(input timing_t t, input logic vert);
    return $signed(vert ? -(t.v_fp + t.v_sync + t.v_bp) : -(t.h_fp + t.h_sync + t.h_bp));
  endfunction
  // A resolution of 0 collapses to a single active position; a sync width of 0 gives an empty window.
  function automatic axis_t axis_bounds(input timing_t t, input logic vert);
    axis_t b;
    logic [CW-1:0] res, fp, sw;
    res = vert ? t.vres : t.hres;
    fp = vert ? t.v_fp : t.h_fp;
    sw = vert ? t.v_sync : t.h_sync;
    b.sta = axis_start(t, vert);
    b.sync_beg = b.sta + $signed(fp);
    b.sync_end = b.sync_beg + $signed(sw);
    b.last = $signed(res == '0 ? '0 : res - CW'(1));
    return b;
  endfunction
endpackage

// File: rtl/video_timing_axis.sv
// video_timing_axis: one signed position counter with load, wrap and sync/active decode
module video_timing_axis
  import video_timing_pkg::*;
(
  input  logic                 video_clk_pix,
  input  logic                 en,
  input  logic                 ld,
  input  logic signed [CW-1:0] ld_val,
  input  axis_t                b,
  output logic signed [CW-1:0] cnt,
  output logic                 wrap,
  output logic                 in_sync,
  output logic                 act
);
  assign wrap = en && cnt == b.last;
  assign in_sync = cnt >= b.sync_beg && cnt < b.sync_end;
  assign act = !cnt[CW-1] && cnt <= b.last;
  // load wins over counting so reset and mode switches restart from the new start
  always_ff @(posedge video_clk_pix)
    cnt <= ld ? ld_val : !en ? cnt : wrap ? b.sta : cnt + CW'(1);
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: runtime-programmable video timing with frame-boundary commits (option: VIDEO_TIMING_LINE_MATCH_EN)
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int COORDSPC = 16,
  parameter int HRES = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int VRES = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int H_POL = 0,
  parameter int V_POL = 0,
  parameter int FCNT_W = 16
) (
  input  logic                       video_clk_pix,
  input  logic                       rst_pix,
  input  logic                       cfg_wr,
  input  logic [3:0]                 cfg_addr,
  input  logic [COORDSPC-1:0]        cfg_data,
  input  logic                       cfg_commit,
  output logic                       cfg_pending,
  output logic                       video_enable,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       frame_start,
  output logic                       line_start,
  output logic signed [COORDSPC-1:0] sx,
  output logic signed [COORDSPC-1:0] sy,
  output logic [FCNT_W-1:0]          frame_count,
  output logic                       line_match
);
  localparam timing_t DEF = '{hres: CW'(HRES), h_fp: CW'(H_FP), h_sync: CW'(H_SYNC), h_bp: CW'(H_BP),
                              vres: CW'(VRES), v_fp: CW'(V_FP), v_sync: CW'(V_SYNC), v_bp: CW'(V_BP),
                              v_pol: 1'(V_POL), h_pol: 1'(H_POL)};
  localparam logic signed [CW-1:0] H_STA = axis_start(DEF, 1'b0);
  localparam logic signed [CW-1:0] V_STA = axis_start(DEF, 1'b1);
  timing_t cur, shd;
  axis_t hb, vb;
  logic signed [CW-1:0] x, y, h_ld, v_ld;
  logic h_wrap, v_wrap, h_in, v_in, h_act, v_act, frame_wrap, apply;
  assign hb = axis_bounds(cur, 1'b0);
  assign vb = axis_bounds(cur, 1'b1);
  assign h_ld = rst_pix ? H_STA : axis_start(shd, 1'b0);
  assign v_ld = rst_pix ? V_STA : axis_start(shd, 1'b1);
  assign frame_wrap = h_wrap && v_wrap;
  assign apply = cfg_pending && frame_wrap;
  video_timing_axis u_h (
    .video_clk_pix(video_clk_pix), .en(1'b1), .ld(rst_pix || apply), .ld_val(h_ld), .b(hb),
    .cnt(x), .wrap(h_wrap), .in_sync(h_in), .act(h_act)
  );
  video_timing_axis u_v (
    .video_clk_pix(video_clk_pix), .en(h_wrap), .ld(rst_pix || apply), .ld_val(v_ld), .b(vb),
    .cnt(y), .wrap(v_wrap), .in_sync(v_in), .act(v_act)
  );
  // shadow writes are frozen while a commit is armed; the armed commit lands on the frame wrap
  always_ff @(posedge video_clk_pix) begin
    if (rst_pix) begin
      cur <= DEF;
      shd <= DEF;
      cfg_pending <= 1'b0;
    end else begin
      cur <= apply ? shd : cur;
      cfg_pending <= cfg_pending ? !frame_wrap : cfg_commit;
      if (cfg_wr && !cfg_pending)
        case (cfg_addr)
          A_HRES:   shd.hres <= cfg_data;
          A_H_FP:   shd.h_fp <= cfg_data;
          A_H_SYNC: shd.h_sync <= cfg_data;
          A_H_BP:   shd.h_bp <= cfg_data;
          A_VRES:   shd.vres <= cfg_data;
          A_V_FP:   shd.v_fp <= cfg_data;
          A_V_SYNC: shd.v_sync <= cfg_data;
          A_V_BP:   shd.v_bp <= cfg_data;
          A_POL:    {shd.v_pol, shd.h_pol} <= cfg_data[1:0];
          default:  ;
        endcase
    end
  end
  // registered outputs, one cycle behind the counters
  always_ff @(posedge video_clk_pix) begin
    if (rst_pix) begin
      video_enable <= 1'b0;
      hsync <= ~DEF.h_pol;
      vsync <= ~DEF.v_pol;
      frame_start <= 1'b0;
      line_start <= 1'b0;
      sx <= H_STA;
      sy <= V_STA;
      frame_count <= '0;
    end else begin
      video_enable <= h_act && v_act;
      hsync <= h_in ? cur.h_pol : ~cur.h_pol;
      vsync <= v_in ? cur.v_pol : ~cur.v_pol;
      frame_start <= x == hb.sta && y == vb.sta;
      line_start <= x == hb.sta;
      sx <= x;
      sy <= y;
      frame_count <= frame_count + FCNT_W'(frame_start);
    end
  end
`ifdef VIDEO_TIMING_LINE_MATCH_EN
  logic [CW-1:0] lcmp;
  // line compare takes effect at once, outside the shadow/commit path
  always_ff @(posedge video_clk_pix) begin
    if (rst_pix) begin
      lcmp <= '0;
      line_match <= 1'b0;
    end else begin
      if (cfg_wr && cfg_addr == A_LCMP) lcmp <= cfg_data;
      line_match <= x == hb.sta && y == $signed(lcmp);
    end
  end
`else
  assign line_match = 1'b0;
`endif
endmodule
